// File: rtl/peg_l2_rs_rmii_rx.sv
// RMII receive RS: dibit sampling, preamble/SFD strip, LSB-first packing into packet words.
// Optional PEG_RMII_RX_STATS_EN adds saturating frame/error counters.
module peg_l2_rs_rmii_rx #(
    parameter int PKT_DATA_W = 64,
    parameter int PKT_SIZE_W = 16
) (
    input  logic                  rmii_ref_clk,
    input  logic                  rst_n,
    input  logic                  config_rs_mii_speed_100_n_10,
    input  logic [1:0]            rmii_rxd,
    input  logic                  rmii_crs_dv,
    input  logic                  rmii_rx_er,
    output logic                  pkt_valid,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [PKT_DATA_W-1:0] pkt_data,
    output logic [PKT_SIZE_W-1:0] pkt_size,
    output logic                  pkt_error
`ifdef PEG_RMII_RX_STATS_EN
    ,
    output logic [15:0]           stat_frame_cnt,
    output logic [15:0]           stat_err_cnt
`endif
);

    localparam int DW = $clog2(PKT_DATA_W / 2);
    localparam int BW = DW - 2;
    localparam int NB = PKT_DATA_W / 8;
    localparam logic [PKT_SIZE_W-1:0] FULL_SZ = PKT_SIZE_W'(PKT_DATA_W);

    typedef enum logic [2:0] {
        IDLE_S,
        PREAMBLE_S,
        RCV_S,
        DROP_S,
        FLUSH_S
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            div_q, div_d;
    logic                  speed_q, speed_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic [PKT_DATA_W-1:0] word_q, word_d;
    logic [PKT_DATA_W-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  sop_pend_q, sop_pend_d;
    logic                  err_q, err_d;
    logic                  low_q, low_d;
    logic [PKT_SIZE_W-1:0] fin_size_q, fin_size_d;

    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [PKT_DATA_W-1:0] data_q, data_d;
    logic [PKT_SIZE_W-1:0] size_q, size_d;
    logic                  perr_q, perr_d;

    logic                  speed100;
    logic                  stb;
    logic [PKT_DATA_W-1:0] word_wr;
    logic [PKT_DATA_W-1:0] cur;
    logic [PKT_DATA_W-1:0] masked;
    logic [BW-1:0]         keep;
    logic                  cur_hv;
    logic                  err_now;
    logic                  fin_err;
    logic                  empty;

    always_comb begin
        speed100 = (state_q == IDLE_S) ? config_rs_mii_speed_100_n_10 : speed_q;
        stb      = speed100 | (div_q == 4'd9);

        if (speed100 || (state_q == IDLE_S && !rmii_crs_dv) || div_q == 4'd9) begin
            div_d = 4'd0;
        end else begin
            div_d = div_q + 4'd1;
        end

        state_d    = state_q;
        speed_d    = speed_q;
        dcnt_d     = dcnt_q;
        word_d     = word_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sop_pend_d = sop_pend_q;
        err_d      = err_q;
        low_d      = low_q;
        fin_size_d = fin_size_q;

        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = '0;
        size_d  = '0;
        perr_d  = 1'b0;

        word_wr = (dcnt_q == '0) ? '0 : word_q;
        word_wr[{dcnt_q, 1'b0} +: 2] = rmii_rxd;
        err_now = err_q | rmii_rx_er;

        // A toggle end drops the byte that holds the toggle dibit.
        if (low_q) begin
            keep   = BW'((dcnt_q - DW'(1)) >> 2);
            cur    = (dcnt_q == '0) ? hold_q : word_q;
            cur_hv = hold_vld_q && (dcnt_q != '0);
        end else begin
            keep   = dcnt_q[DW-1:2];
            cur    = word_q;
            cur_hv = hold_vld_q;
        end
        masked = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(keep)) begin
                masked[8*b +: 8] = cur[8*b +: 8];
            end
        end
        empty   = (keep == '0) && !cur_hv;
        fin_err = err_now | low_q | empty;

        unique case (state_q)
            IDLE_S: begin
                if (stb && rmii_crs_dv && rmii_rxd == 2'b01) begin
                    state_d = PREAMBLE_S;
                    speed_d = config_rs_mii_speed_100_n_10;
                end
            end
            PREAMBLE_S: begin
                if (stb) begin
                    if (!rmii_crs_dv) begin
                        state_d = IDLE_S;
                    end else if (rmii_rxd == 2'b11) begin
                        state_d    = RCV_S;
                        dcnt_d     = '0;
                        word_d     = '0;
                        hold_vld_d = 1'b0;
                        sop_pend_d = 1'b1;
                        err_d      = 1'b0;
                        low_d      = 1'b0;
                    end else if (rmii_rxd == 2'b10) begin
                        state_d = DROP_S;
                        low_d   = 1'b0;
                    end
                end
            end
            DROP_S: begin
                if (stb) begin
                    if (rmii_crs_dv) begin
                        low_d = 1'b0;
                    end else if (low_q) begin
                        state_d = IDLE_S;
                        low_d   = 1'b0;
                    end else begin
                        low_d = 1'b1;
                    end
                end
            end
            RCV_S: begin
                if (stb) begin
                    if (!rmii_crs_dv && (low_q || dcnt_q[1:0] == 2'b00)) begin
                        state_d    = IDLE_S;
                        dcnt_d     = '0;
                        low_d      = 1'b0;
                        hold_vld_d = 1'b0;
                        sop_pend_d = 1'b0;
                        err_d      = fin_err;
                        valid_d    = 1'b1;
                        sop_d      = sop_pend_q;
                        perr_d     = fin_err;
                        if (keep != '0 && cur_hv) begin
                            state_d    = FLUSH_S;
                            data_d     = hold_q;
                            size_d     = FULL_SZ;
                            perr_d     = 1'b0;
                            hold_d     = masked;
                            fin_size_d = PKT_SIZE_W'({keep, 3'b000});
                        end else if (keep != '0) begin
                            eop_d  = 1'b1;
                            data_d = masked;
                            size_d = PKT_SIZE_W'({keep, 3'b000});
                        end else if (cur_hv) begin
                            eop_d  = 1'b1;
                            data_d = hold_q;
                            size_d = FULL_SZ;
                        end else begin
                            eop_d = 1'b1;
                        end
                    end else begin
                        low_d  = !rmii_crs_dv;
                        err_d  = err_now;
                        dcnt_d = dcnt_q + DW'(1);
                        word_d = word_wr;
                        if (hold_vld_q) begin
                            valid_d    = 1'b1;
                            sop_d      = sop_pend_q;
                            data_d     = hold_q;
                            size_d     = FULL_SZ;
                            sop_pend_d = 1'b0;
                            hold_vld_d = 1'b0;
                        end
                        if (dcnt_q == {DW{1'b1}}) begin
                            hold_d     = word_wr;
                            hold_vld_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH_S: begin
                state_d = IDLE_S;
                valid_d = 1'b1;
                eop_d   = 1'b1;
                data_d  = hold_q;
                size_d  = fin_size_q;
                perr_d  = err_q;
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_S;
            div_q      <= '0;
            speed_q    <= 1'b0;
            dcnt_q     <= '0;
            word_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            sop_pend_q <= 1'b0;
            err_q      <= 1'b0;
            low_q      <= 1'b0;
            fin_size_q <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
            size_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            speed_q    <= speed_d;
            dcnt_q     <= dcnt_d;
            word_q     <= word_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sop_pend_q <= sop_pend_d;
            err_q      <= err_d;
            low_q      <= low_d;
            fin_size_q <= fin_size_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            data_q     <= data_d;
            size_q     <= size_d;
            perr_q     <= perr_d;
        end
    end

    assign pkt_valid = valid_q;
    assign pkt_sop   = sop_q;
    assign pkt_eop   = eop_q;
    assign pkt_data  = data_q;
    assign pkt_size  = size_q;
    assign pkt_error = perr_q;

`ifdef PEG_RMII_RX_STATS_EN
    logic [15:0] sfc_q, sfc_d;
    logic [15:0] sec_q, sec_d;

    always_comb begin
        sfc_d = sfc_q;
        sec_d = sec_q;
        if (valid_d && eop_d) begin
            if (sfc_q != 16'hFFFF) begin
                sfc_d = sfc_q + 16'd1;
            end
            if (perr_d && sec_q != 16'hFFFF) begin
                sec_d = sec_q + 16'd1;
            end
        end
    end

    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sfc_q <= '0;
            sec_q <= '0;
        end else begin
            sfc_q <= sfc_d;
            sec_q <= sec_d;
        end
    end

    assign stat_frame_cnt = sfc_q;
    assign stat_err_cnt   = sec_q;
`endif

endmodule
